pipe_latch_skid: RTL



---
 rtl/pipe_latch_skid_pkg.sv | 22 ++
 rtl/pipe_latch_skid_if.sv | 27 ++
 rtl/pipe_latch_skid_entry.sv | 35 +++
 rtl/pipe_latch_skid.sv | 92 +++++++++
 4 files changed

// File: rtl/pipe_latch_skid_pkg.sv
// Shared pipeline types: occupancy type, bubble counter width and the
// fetch/decode payload layout used to size the fetch/decode latch instance.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  pipe_occ_t;

  localparam int PIPE_BUBBLE_CNT_W = 16;

  typedef struct packed {
    word_t instr;
    word_t npc;
    word_t next_pc;
  } fd_payload_t;

  localparam int FD_DATA_W = $bits(fd_payload_t);

  function automatic pipe_occ_t pipe_occ(input logic h_valid, input logic s_valid);
    return {1'b0, h_valid} + {1'b0, s_valid};
  endfunction

endpackage

// File: rtl/pipe_latch_skid_if.sv
// Handshake bundle for one pipeline latch. Modports are seen from the latch:
// up = producer side, down = consumer side, ctrl = stall/flush/monitoring.
interface pipe_latch_if
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = FD_DATA_W,
  parameter int CNT_W  = PIPE_BUBBLE_CNT_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              stall;
  logic              flush;
  pipe_occ_t         occupancy;
  logic [CNT_W-1:0]  bubble_cnt;
  logic              bubble_clr;

  modport up   (input in_valid, input in_data, output in_ready);
  modport down (output out_valid, output out_data, input out_ready);
  modport ctrl (input stall, input flush, input bubble_clr,
                output occupancy, output bubble_cnt);

endinterface

// File: rtl/pipe_latch_skid_entry.sv
// One valid+data storage slot. Reset/clear beats load, load beats drop;
// drop only invalidates so the stale data stays put.
module pipe_latch_entry #(
  parameter int              DATA_W     = 96,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_drop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_valid <= 1'b0;
      r_data  <= RESET_DATA;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_latch_skid.sv
// Generic inter-stage pipeline latch with valid/ready, stall, flush and a
// saturating bubble counter. Define PIPE_LATCH_SKID_EN for the 2-entry skid buffer.
module pipe_latch_skid
  import cpu_types_pkg::*;
#(
  parameter int                DATA_W     = FD_DATA_W,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter int                CNT_W      = PIPE_BUBBLE_CNT_W
) (
  input logic         CLK,
  input logic         RST,
  pipe_latch_if.up    up_if,
  pipe_latch_if.down  down_if,
  pipe_latch_if.ctrl  ctrl_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_h_valid;
  logic [DATA_W-1:0] w_h_data;
  logic [DATA_W-1:0] w_h_din;
  logic              w_h_load;
  logic              w_h_drop;
  logic              w_s_valid;
  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  r_bubble_cnt;

  assign w_pop  = w_h_valid & down_if.out_ready & ~ctrl_if.stall;
  assign w_push = up_if.in_valid & w_in_ready;

`ifdef PIPE_LATCH_SKID_EN
  logic              w_s_load;
  logic              w_s_drop;
  logic [DATA_W-1:0] w_s_data;

  // in_ready depends only on the skid slot, so ready never sees out_ready/stall.
  assign w_in_ready = ~w_s_valid;
  assign w_h_load   = w_s_valid ? w_pop : (w_push & (~w_h_valid | w_pop));
  assign w_h_din    = w_s_valid ? w_s_data : up_if.in_data;
  assign w_s_load   = w_h_valid & ~w_s_valid & w_push & ~w_pop;
  assign w_s_drop   = w_s_valid & w_pop;

  pipe_latch_entry #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_skid (
    .CLK     (CLK),
    .RST     (RST),
    .i_clr   (ctrl_if.flush),
    .i_load  (w_s_load),
    .i_drop  (w_s_drop),
    .i_data  (up_if.in_data),
    .o_valid (w_s_valid),
    .o_data  (w_s_data)
  );
`else
  assign w_in_ready = ~w_h_valid | (down_if.out_ready & ~ctrl_if.stall);
  assign w_h_load   = w_push;
  assign w_h_din    = up_if.in_data;
  assign w_s_valid  = 1'b0;
`endif

  assign w_h_drop = w_pop & ~w_h_load;

  pipe_latch_entry #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_head (
    .CLK     (CLK),
    .RST     (RST),
    .i_clr   (ctrl_if.flush),
    .i_load  (w_h_load),
    .i_drop  (w_h_drop),
    .i_data  (w_h_din),
    .o_valid (w_h_valid),
    .o_data  (w_h_data)
  );

  // Flush deliberately leaves the counter alone; only RST and bubble_clr zero it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bubble_cnt <= '0;
    end else if (ctrl_if.bubble_clr) begin
      r_bubble_cnt <= '0;
    end else if (~w_h_valid && down_if.out_ready && (r_bubble_cnt != CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign up_if.in_ready     = w_in_ready;
  assign down_if.out_valid  = w_h_valid;
  assign down_if.out_data   = w_h_data;
  assign ctrl_if.occupancy  = pipe_occ(w_h_valid, w_s_valid);
  assign ctrl_if.bubble_cnt = r_bubble_cnt;

endmodule
